// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared widths, arbiter state encoding and ALU opcode names.
package alu_arbiter_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int OP_WIDTH   = 3;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic [OP_WIDTH-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared combinational ALU: 3-bit opcode, two operands, one result of equal width.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [WORD_WIDTH-1:0] in1,
    input  logic [WORD_WIDTH-1:0] in2,
    output logic [WORD_WIDTH-1:0] out
);

    always_comb begin
        out = '0;
        case (alu_op_t'(op))
            ALU_ADD: out = in1 + in2;
            ALU_SUB: out = in1 - in2;
            ALU_AND: out = in1 & in2;
            ALU_OR:  out = in1 | in2;
            ALU_XOR: out = in1 ^ in2;
            ALU_SHL: out = in1 << 1;
            ALU_SHR: out = in1 >> 1;
            ALU_SLT: out = {{(WORD_WIDTH-1){1'b0}}, (in1 < in2)};
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - combinational two-way round-robin picker with optional sticky grant.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic lock,
    output logic grant,
    output logic any
);

    logic last_valid;

    always_comb begin
        any        = valid0 | valid1;
        last_valid = last_grant ? valid1 : valid0;
        if (lock && last_valid) begin
            grant = last_grant;
        end else if (valid0 && valid1) begin
            grant = ~last_grant;
        end else begin
            grant = valid1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters with round-robin and held responses.
// Optional sticky grant via ALU_ARBITER_LOCK_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [WORD_WIDTH-1:0] req0_in1,
    input  logic [WORD_WIDTH-1:0] req0_in2,
`ifdef ALU_ARBITER_LOCK_EN
    input  logic                  req0_lock,
`endif
    output logic                  req0_ready,
    output logic                  resp0_valid,
    output logic [WORD_WIDTH-1:0] resp0_data,
    input  logic                  resp0_ack,
    input  logic                  req1_valid,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [WORD_WIDTH-1:0] req1_in1,
    input  logic [WORD_WIDTH-1:0] req1_in2,
`ifdef ALU_ARBITER_LOCK_EN
    input  logic                  req1_lock,
`endif
    output logic                  req1_ready,
    output logic                  resp1_valid,
    output logic [WORD_WIDTH-1:0] resp1_data,
    input  logic                  resp1_ack,
    output logic                  busy
);

    arb_state_t            state;
    logic                  last_grant;
    logic                  owner;
    logic                  lock_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [WORD_WIDTH-1:0] in1_q;
    logic [WORD_WIDTH-1:0] in2_q;
    logic [WORD_WIDTH-1:0] alu_out;
    logic                  grant;
    logic                  any;
    logic                  accept;
    logic                  owner_ack;

`ifndef ALU_ARBITER_LOCK_EN
    assign lock_q = 1'b0;
`endif

    rr_arb2 u_rr (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .lock       (lock_q),
        .grant      (grant),
        .any        (any)
    );

    alu u_alu (
        .op  (op_q),
        .in1 (in1_q),
        .in2 (in2_q),
        .out (alu_out)
    );

    assign accept     = (state == ARB_IDLE) && any;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign owner_ack  = owner ? resp1_ack : resp0_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            busy        <= 1'b0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            op_q        <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_data  <= '0;
            resp1_data  <= '0;
`ifdef ALU_ARBITER_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        op_q       <= grant ? req1_op  : req0_op;
                        in1_q      <= grant ? req1_in1 : req0_in1;
                        in2_q      <= grant ? req1_in2 : req0_in2;
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= ARB_EXEC;
                        busy       <= 1'b1;
`ifdef ALU_ARBITER_LOCK_EN
                        lock_q     <= grant ? req1_lock : req0_lock;
                    end else if (lock_q) begin
                        // Nobody valid means the locked port dropped its request.
                        lock_q     <= 1'b0;
`endif
                    end
                end
                ARB_EXEC: begin
                    if (owner) begin
                        resp1_data  <= alu_out;
                        resp1_valid <= 1'b1;
                    end else begin
                        resp0_data  <= alu_out;
                        resp0_valid <= 1'b1;
                    end
                    state <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (owner_ack) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        state       <= ARB_IDLE;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp1_valid;
    logic [15:0] resp0_data, resp1_data;
    logic        resp0_ack, resp1_ack;
    logic        busy;
`ifdef ALU_ARBITER_LOCK_EN
    logic        req0_lock, req1_lock;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_op     (req0_op),
        .req0_in1    (req0_in1),
        .req0_in2    (req0_in2),
`ifdef ALU_ARBITER_LOCK_EN
        .req0_lock   (req0_lock),
`endif
        .req0_ready  (req0_ready),
        .resp0_valid (resp0_valid),
        .resp0_data  (resp0_data),
        .resp0_ack   (resp0_ack),
        .req1_valid  (req1_valid),
        .req1_op     (req1_op),
        .req1_in1    (req1_in1),
        .req1_in2    (req1_in2),
`ifdef ALU_ARBITER_LOCK_EN
        .req1_lock   (req1_lock),
`endif
        .req1_ready  (req1_ready),
        .resp1_valid (resp1_valid),
        .resp1_data  (resp1_data),
        .resp1_ack   (resp1_ack),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req0_valid = 0; req0_op = 0; req0_in1 = 0; req0_in2 = 0;
        req1_valid = 0; req1_op = 0; req1_in1 = 0; req1_in2 = 0;
        resp0_ack = 0; resp1_ack = 0;
`ifdef ALU_ARBITER_LOCK_EN
        req0_lock = 0; req1_lock = 0;
`endif
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Runs one full accept/exec/response/ack cycle for the expected winning port.
    task automatic serve(input int p, input logic [15:0] exp);
        #1;
        check("ready0_idle", req0_ready, p == 0);
        check("ready1_idle", req1_ready, p == 1);
        step();
        check("busy_exec", busy, 1);
        check("readies_exec", {req0_ready, req1_ready}, 0);
        step();
        check("resp_valid", p ? {resp0_valid, resp1_valid} : {resp1_valid, resp0_valid}, 2'b01);
        check("resp_data", p ? resp1_data : resp0_data, exp);
        if (p == 1) resp1_ack = 1; else resp0_ack = 1;
        step();
        resp0_ack = 0; resp1_ack = 0;
        check("resp_cleared", {resp0_valid, resp1_valid, busy}, 0);
    endtask

    initial begin
        // Reset state
        reset_dut();
        check("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
        check("rst_resp_data", {resp0_data, resp1_data}, 0);
        check("rst_busy", busy, 0);
        check("rst_readies", {req0_ready, req1_ready}, 0);

        // Single request on port 0: 5 + 7
        req0_valid = 1; req0_op = 3'd0; req0_in1 = 16'd5; req0_in2 = 16'd7;
        #1;
        check("t1_ready0", req0_ready, 1);
        check("t1_ready1", req1_ready, 0);
        step();
        req0_valid = 0;
        check("t1_exec_busy", busy, 1);
        check("t1_exec_valid", resp0_valid, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            check("t1_hold_valid", resp0_valid, 1);
            check("t1_hold_data", resp0_data, 16'd12);
            check("t1_hold_busy", busy, 1);
            step();
        end
        resp0_ack = 1;
        step();
        resp0_ack = 0;
        check("t1_ack_valid", resp0_valid, 0);
        check("t1_ack_busy", busy, 0);
        check("t1_data_kept", resp0_data, 16'd12);

        // Tie from reset: 0,1,0,1 alternation
        reset_dut();
        req0_valid = 1; req0_op = 3'd1; req0_in1 = 16'd5; req0_in2 = 16'd7;
        req1_valid = 1; req1_op = 3'd2; req1_in1 = 16'd9; req1_in2 = 16'd3;
        for (int i = 0; i < 8; i++) begin
            serve(i % 2, (i % 2) ? 16'h0001 : 16'hFFFE);
        end

        // Held response on port 1 with port 0 pending
        req0_valid = 0;
        #1;
        check("t3_ready1", req1_ready, 1);
        step();
        req0_valid = 1;
        step();
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", resp1_valid, 1);
            check("t3_hold_data", resp1_data, 16'h0001);
            check("t3_hold_readies", {req0_ready, req1_ready}, 0);
            resp0_ack = (i == 4);
            step();
        end
        resp0_ack = 0;
        resp1_ack = 1;
        step();
        resp1_ack = 0;
        serve(0, 16'hFFFE);

        // Operand change after accept does not affect result: 5 | 7
        req1_valid = 0;
        req0_op = 3'd3; req0_in1 = 16'd5; req0_in2 = 16'd7;
        #1;
        check("t4_ready0", req0_ready, 1);
        step();
        req0_in1 = 16'd99; req0_op = 3'd0;
        step();
        check("t4_valid", resp0_valid, 1);
        check("t4_data", resp0_data, 16'd7);
        resp0_ack = 1;
        step();
        resp0_ack = 0;
        req0_valid = 0;

        // Asynchronous reset during EXEC
        req0_valid = 1; req0_op = 3'd0; req0_in1 = 16'd5; req0_in2 = 16'd7;
        step();
        check("t5_exec_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        check("t5_rst_valid", {resp0_valid, resp1_valid}, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_data", resp0_data, 0);
        req0_valid = 0;
        #2 rst_n = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            check("t5_no_stale", {resp0_valid, resp1_valid, busy}, 0);
            step();
        end
        req0_valid = 1;
        req1_valid = 1; req1_op = 3'd2; req1_in1 = 16'd9; req1_in2 = 16'd3;
        serve(0, 16'd12);
        req0_valid = 0; req1_valid = 0;

`ifdef ALU_ARBITER_LOCK_EN
        // Sticky grant on port 1 while port 0 keeps asking
        reset_dut();
        req1_valid = 1; req1_lock = 1; req1_op = 3'd2; req1_in1 = 16'd9; req1_in2 = 16'd3;
        #1;
        check("lk_ready1", req1_ready, 1);
        step();
        req0_valid = 1; req0_op = 3'd1; req0_in1 = 16'd5; req0_in2 = 16'd7;
        step();
        check("lk_first_data", resp1_data, 16'h0001);
        resp1_ack = 1;
        step();
        resp1_ack = 0;
        serve(1, 16'h0001);
        req1_lock = 0;
        serve(1, 16'h0001);
        serve(0, 16'hFFFE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
